// File: rtl/mcpu_pkg.sv
// Shared MCPU definitions: widths, opcodes, register-file commands,
// ALU selects, sequencer states and the decoder's output bundle.
package mcpu_pkg;

  localparam int WORD_SIZE    = 16;
  localparam int OPERAND_SIZE = 4;
  localparam int OPCODE_SIZE  = 4;
  localparam int PC_WIDTH     = 8;

  localparam logic [OPCODE_SIZE-1:0] OP_NOP   = 4'h0;
  localparam logic [OPCODE_SIZE-1:0] OP_ADD   = 4'h1;
  localparam logic [OPCODE_SIZE-1:0] OP_SUB   = 4'h2;
  localparam logic [OPCODE_SIZE-1:0] OP_AND   = 4'h3;
  localparam logic [OPCODE_SIZE-1:0] OP_OR    = 4'h4;
  localparam logic [OPCODE_SIZE-1:0] OP_MOV   = 4'h5;
  localparam logic [OPCODE_SIZE-1:0] OP_LOAD  = 4'h6;
  localparam logic [OPCODE_SIZE-1:0] OP_STORE = 4'h7;
  localparam logic [OPCODE_SIZE-1:0] OP_JMP   = 4'h8;
  localparam logic [OPCODE_SIZE-1:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    NORMAL_EX      = 2'd0,
    MOV_INTERNAL   = 2'd1,
    LOAD_FROM_DATA = 2'd2,
    DO_NOTHING     = 2'd3
  } regsetcmd_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3
  } aluop_e;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    WAIT_I = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  typedef struct packed {
    aluop_e     aluop;
    regsetcmd_e regsetcmd;
    logic       is_mem;
    logic       is_load;
    logic       writes_reg;
    logic       is_jmp;
    logic       is_halt;
  } dec_t;

  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] pc);
    return pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Jump target is the {op2,op3} byte, fitted to the PC width.
  function automatic logic [PC_WIDTH-1:0] jmp_target(input logic [WORD_SIZE-1:0] ir);
    return PC_WIDTH'(ir[2*OPERAND_SIZE-1:0]);
  endfunction

endpackage

// File: rtl/mcpu_controlunit_if.sv
// Bus between the MCPU sequencer and its instruction memory, data memory
// and register file. master = sequencer side.
interface mcpu_controlunit_if;
  import mcpu_pkg::*;

  logic [PC_WIDTH-1:0]     pc;
  logic                    ifetch;
  logic [WORD_SIZE-1:0]    instr;
  logic                    instr_valid;
  logic [OPERAND_SIZE-1:0] op1;
  logic [OPERAND_SIZE-1:0] op2;
  logic [OPERAND_SIZE-1:0] op3;
  logic [2:0]              aluop;
  logic [1:0]              regsetcmd;
  logic                    regsetwb;
  logic                    mem_rd;
  logic                    mem_wr;
  logic                    mem_ready;
  logic                    halted;

  modport master (
    output pc, ifetch, op1, op2, op3, aluop, regsetcmd, regsetwb,
           mem_rd, mem_wr, halted,
    input  instr, instr_valid, mem_ready
  );

  modport slave (
    input  pc, ifetch, op1, op2, op3, aluop, regsetcmd, regsetwb,
           mem_rd, mem_wr, halted,
    output instr, instr_valid, mem_ready
  );

endinterface

// File: rtl/mcpu_decoder.sv
// Combinational opcode classifier for the MCPU sequencer.
module mcpu_decoder
  import mcpu_pkg::*;
(
  input  logic [OPCODE_SIZE-1:0] opcode,
  output dec_t                   dec
);

  // Map each opcode to its control bundle; unknown opcodes behave as NOP.
  always_comb begin
    dec            = '0;
    dec.aluop      = ALU_ADD;
    dec.regsetcmd  = DO_NOTHING;
    case (opcode)
      OP_ADD:   begin dec.aluop = ALU_ADD; dec.regsetcmd = NORMAL_EX; dec.writes_reg = 1'b1; end
      OP_SUB:   begin dec.aluop = ALU_SUB; dec.regsetcmd = NORMAL_EX; dec.writes_reg = 1'b1; end
      OP_AND:   begin dec.aluop = ALU_AND; dec.regsetcmd = NORMAL_EX; dec.writes_reg = 1'b1; end
      OP_OR:    begin dec.aluop = ALU_OR;  dec.regsetcmd = NORMAL_EX; dec.writes_reg = 1'b1; end
      OP_MOV:   begin dec.regsetcmd = MOV_INTERNAL; dec.writes_reg = 1'b1; end
      OP_LOAD:  begin
        dec.regsetcmd  = LOAD_FROM_DATA;
        dec.is_mem     = 1'b1;
        dec.is_load    = 1'b1;
        dec.writes_reg = 1'b1;
      end
      OP_STORE: dec.is_mem  = 1'b1;
      OP_JMP:   dec.is_jmp  = 1'b1;
      OP_HALT:  dec.is_halt = 1'b1;
      OP_NOP:   dec.is_jmp  = 1'b0;
      default:  dec.is_jmp  = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcpu_controlunit.sv
// MCPU multi-cycle sequencer: fetch, decode, execute, memory and write-back.
// Optional retired-instruction counter enabled by MCPU_CTRL_PERFCNT_EN.
module mcpu_controlunit
  import mcpu_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  mcpu_controlunit_if.master bus
`ifdef MCPU_CTRL_PERFCNT_EN
  ,
  output logic [15:0]        retired
`endif
);

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [WORD_SIZE-1:0]    ir_q, ir_d;
  logic [OPERAND_SIZE-1:0] op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  aluop_e                  aluop_q, aluop_d;
  regsetcmd_e              regsetcmd_q, regsetcmd_d;
  logic                    regsetwb_q, regsetwb_d;
  logic                    ifetch_q, ifetch_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;
  logic                    halted_q, halted_d;
  dec_t                    dec_s;

  mcpu_decoder u_decoder (
    .opcode (ir_q[WORD_SIZE-1 -: OPCODE_SIZE]),
    .dec    (dec_s)
  );

  // Next-state and registered-output computation for the sequencer.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    op3_d       = op3_q;
    aluop_d     = aluop_q;
    regsetcmd_d = regsetcmd_q;
    regsetwb_d  = 1'b0;
    ifetch_d    = 1'b0;
    mem_rd_d    = mem_rd_q;
    mem_wr_d    = mem_wr_q;
    halted_d    = halted_q;
    case (state_q)
      FETCH: begin
        ifetch_d = 1'b1;
        state_d  = WAIT_I;
      end
      WAIT_I: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end else begin
          state_d = WAIT_I;
        end
      end
      DECODE: begin
        // Operand fields and command stay put until the next DECODE so the
        // register file sees stable inputs around the write strobe.
        op1_d       = ir_q[11:8];
        op2_d       = ir_q[7:4];
        op3_d       = ir_q[3:0];
        aluop_d     = dec_s.aluop;
        regsetcmd_d = dec_s.regsetcmd;
        state_d     = EXEC;
      end
      EXEC: begin
        if (dec_s.is_halt) begin
          halted_d = 1'b1;
          state_d  = HALT;
        end else if (dec_s.is_mem) begin
          mem_rd_d = dec_s.is_load;
          mem_wr_d = ~dec_s.is_load;
          state_d  = MEM;
        end else if (dec_s.writes_reg) begin
          state_d = WB;
        end else if (dec_s.is_jmp) begin
          pc_d    = jmp_target(ir_q);
          state_d = FETCH;
        end else begin
          pc_d    = pc_inc(pc_q);
          state_d = FETCH;
        end
      end
      MEM: begin
        if (bus.mem_ready) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (dec_s.is_load) begin
            state_d = WB;
          end else begin
            pc_d    = pc_inc(pc_q);
            state_d = FETCH;
          end
        end else begin
          state_d = MEM;
        end
      end
      WB: begin
        regsetwb_d = 1'b1;
        pc_d       = pc_inc(pc_q);
        state_d    = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= FETCH;
      pc_q        <= '0;
      ir_q        <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      op3_q       <= '0;
      aluop_q     <= ALU_ADD;
      regsetcmd_q <= DO_NOTHING;
      regsetwb_q  <= 1'b0;
      ifetch_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      op3_q       <= op3_d;
      aluop_q     <= aluop_d;
      regsetcmd_q <= regsetcmd_d;
      regsetwb_q  <= regsetwb_d;
      ifetch_q    <= ifetch_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ifetch    = ifetch_q;
  assign bus.op1       = op1_q;
  assign bus.op2       = op2_q;
  assign bus.op3       = op3_q;
  assign bus.aluop     = aluop_q;
  assign bus.regsetcmd = regsetcmd_q;
  assign bus.regsetwb  = regsetwb_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.halted    = halted_q;

`ifdef MCPU_CTRL_PERFCNT_EN
  logic        retire_s;
  logic [15:0] retired_q, retired_d;

  // An instruction retires when it leaves its last state; HALT never retires.
  always_comb begin
    retire_s  = (state_q == WB) ||
                ((state_q == MEM) && bus.mem_ready && !dec_s.is_load) ||
                ((state_q == EXEC) && !dec_s.is_halt && !dec_s.is_mem && !dec_s.writes_reg);
    retired_d = retired_q + {15'd0, retire_s};
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= 16'd0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mcpu_controlunit.sv
// Scoreboard bench for mcpu_controlunit: an instruction-level model predicts
// fetch addresses, write-backs, memory strobes and per-instruction latency.
module tb_mcpu_controlunit;
  import mcpu_pkg::*;

  localparam int          NUM_INSTR  = 60;
  localparam logic [29:0] RESET_OUTS = {8'h00, 1'b0, 12'h000, 3'd0, 2'd3, 4'b0000};
  localparam logic [1:0]  K_WB = 2'd0;
  localparam logic [1:0]  K_RD = 2'd1;
  localparam logic [1:0]  K_WR = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] ops;
    logic [1:0]  cmd;
    logic [2:0]  alu;
    logic        alu_chk;
  } ev_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [11:0] ops;
    logic [1:0]  cmd;
  } fe_t;

  logic clk;
  logic reset_n;
  mcpu_controlunit_if bus ();
`ifdef MCPU_CTRL_PERFCNT_EN
  logic [15:0] retired;
`endif

  mcpu_controlunit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef MCPU_CTRL_PERFCNT_EN
    ,
    .retired (retired)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   passed = 0;
  fe_t  fe_q[$];
  ev_t  ev_q[$];
  int   lat_q[$];
  int   memlen_q[$];
  bit   run_en = 1'b0;
  bit   mon_en = 1'b0;
  bit   load_mode = 1'b0;
  int   issued = 0;
  int   next_mwait = 0;
  int   retired_m = 0;
  logic [7:0] pc_m = 8'h00;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got no matching DUT event, required one", name);
  endtask

  function automatic logic [29:0] outs();
    return {bus.pc, bus.ifetch, bus.op1, bus.op2, bus.op3, bus.aluop,
            bus.regsetcmd, bus.regsetwb, bus.mem_rd, bus.mem_wr, bus.halted};
  endfunction

  function automatic logic [1:0] cmd_of(input logic [3:0] opc);
    if (opc >= 4'd1 && opc <= 4'd4) return 2'd0;
    if (opc == 4'd5) return 2'd1;
    if (opc == 4'd6) return 2'd2;
    return 2'd3;
  endfunction

  // Instruction-level reference: what the next fetch, events and latency must be.
  task automatic issue(input logic [15:0] ins, input int iw, input int mw);
    logic [3:0] opc;
    ev_t        e;
    fe_t        f;
    int         lat;
    logic [7:0] npc;
    opc       = ins[15:12];
    npc       = pc_m + 8'd1;
    e.ops     = ins[11:0];
    e.cmd     = cmd_of(opc);
    e.alu     = 3'(opc - 4'd1);
    e.alu_chk = (opc >= 4'd1 && opc <= 4'd4);
    lat       = 4;
    case (opc)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin e.kind = K_WB; ev_q.push_back(e); lat = 5; end
      4'd6: begin
        e.kind = K_RD; ev_q.push_back(e);
        e.kind = K_WB; ev_q.push_back(e);
        memlen_q.push_back(mw + 1);
        lat = 6 + mw;
      end
      4'd7: begin e.kind = K_WR; ev_q.push_back(e); memlen_q.push_back(mw + 1); lat = 5 + mw; end
      4'd8: npc = ins[7:0];
      default: lat = 4;
    endcase
    next_mwait = mw;
    if (opc != 4'hF) begin
      lat_q.push_back(lat + iw);
      f.pc = npc; f.ops = ins[11:0]; f.cmd = cmd_of(opc);
      fe_q.push_back(f);
      pc_m = npc;
      retired_m++;
    end
  endtask

  task automatic pick(input int k, output logic [15:0] ins, output int iw, output int mw);
    iw = 0;
    mw = 0;
    case (k)
      0: begin ins = 16'h1123; iw = 1; end
      1: ins = 16'h5310;
      2: begin ins = 16'h6240; mw = 3; end
      3: begin ins = 16'h7120; mw = 2; end
      4: ins = 16'h8010;
      5: ins = 16'h80FE;
      6: ins = 16'h0000;
      7: ins = 16'h0000;
      default: begin
        if (k == NUM_INSTR) ins = 16'hF000;
        else begin
          ins = {4'($urandom_range(0, 14)), 12'($urandom)};
          iw  = $urandom_range(0, 2);
          mw  = $urandom_range(0, 3);
        end
      end
    endcase
  endtask

  // Instruction memory responder with random wait states and stray valids.
  initial begin
    int cnt; bit pend; logic [15:0] ins; int iw; int mw;
    cnt = 0; pend = 1'b0; ins = 16'h0000;
    bus.instr = 16'h0000; bus.instr_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!run_en) begin
        bus.instr_valid = 1'b0; pend = 1'b0;
      end else begin
        if (bus.ifetch) begin
          if (load_mode) begin ins = 16'h6240; iw = 0; next_mwait = 10; end
          else if (issued <= NUM_INSTR) begin
            pick(issued, ins, iw, mw); issue(ins, iw, mw); issued++;
          end else begin ins = 16'h0000; iw = 0; end
          cnt = iw; pend = 1'b1;
        end
        if (pend) begin
          if (cnt == 0) begin bus.instr = ins; bus.instr_valid = 1'b1; pend = 1'b0; end
          else begin bus.instr = 16'($urandom); bus.instr_valid = 1'b0; cnt--; end
        end else begin
          bus.instr = 16'($urandom); bus.instr_valid = ($urandom_range(0, 3) == 0);
        end
      end
    end
  end

  // Data memory responder with random completion delay and stray readies.
  initial begin
    int cnt; bit act;
    cnt = 0; act = 1'b0; bus.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!run_en) begin bus.mem_ready = 1'b0; act = 1'b0; end
      else if (act) begin
        if (bus.mem_ready) begin act = 1'b0; bus.mem_ready = 1'b0; end
        else begin cnt--; bus.mem_ready = (cnt == 0); end
      end else if (bus.mem_rd || bus.mem_wr) begin
        act = 1'b1; cnt = next_mwait; bus.mem_ready = (cnt == 0);
      end else bus.mem_ready = ($urandom_range(0, 3) == 0);
    end
  end

  // Monitor: pops expectations whenever the DUT presents an observable event.
  initial begin
    int cyc; int last_if; int slen; logic prev_s; fe_t f; ev_t e;
    cyc = 0; last_if = -1; slen = 0; prev_s = 1'b0;
    forever begin
      @(posedge clk); #1; cyc++;
      if (!mon_en) begin last_if = -1; prev_s = 1'b0; slen = 0; end
      else begin
        if (bus.ifetch) begin
          if (fe_q.size() == 0) fail_now("ifetch_unexpected");
          else begin
            f = fe_q.pop_front();
            chk("ifetch_state", {bus.pc, bus.op1, bus.op2, bus.op3, bus.regsetcmd}, f);
          end
          if (last_if >= 0) begin
            if (lat_q.size() == 0) fail_now("latency_missing");
            else chk("instr_latency", cyc - last_if, lat_q.pop_front());
          end
          last_if = cyc;
        end
        if (bus.regsetwb) begin
          chk("wb_cmd_not_nothing", bus.regsetcmd != 2'd3, 1);
          if (ev_q.size() == 0) fail_now("wb_unexpected");
          else begin
            e = ev_q.pop_front();
            chk("wb_kind", K_WB, e.kind);
            chk("wb_fields", {bus.op1, bus.op2, bus.op3, bus.regsetcmd}, {e.ops, e.cmd});
            if (e.alu_chk) chk("wb_aluop", bus.aluop, e.alu);
          end
        end
        if ((bus.mem_rd || bus.mem_wr) && !prev_s) begin
          if (ev_q.size() == 0) fail_now("mem_unexpected");
          else begin e = ev_q.pop_front(); chk("mem_kind", {bus.mem_wr, bus.mem_rd}, e.kind); end
          slen = 0;
        end
        if (bus.mem_rd || bus.mem_wr) slen++;
        else if (prev_s) begin
          if (memlen_q.size() == 0) fail_now("mem_len_missing");
          else chk("mem_strobe_len", slen, memlen_q.pop_front());
        end
        prev_s = bus.mem_rd || bus.mem_wr;
      end
    end
  end

  initial begin
    bit saw;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1 chk("reset_async", outs(), RESET_OUTS);
    repeat (2) @(negedge clk);
    chk("reset_held", outs(), RESET_OUTS);
`ifdef MCPU_CTRL_PERFCNT_EN
    chk("retired_reset", retired, 16'd0);
`endif
    fe_q.push_back({8'h00, 12'h000, 2'd3});
    pc_m = 8'h00;
    reset_n = 1'b1; run_en = 1'b1; mon_en = 1'b1;

    for (int i = 0; i < 20000 && issued <= NUM_INSTR; i++) @(negedge clk);
    if (issued <= NUM_INSTR) fail_now("program_timeout");
    for (int i = 0; i < 20 && !bus.halted; i++) @(negedge clk);
    chk("halted_set", bus.halted, 1'b1);
    repeat (20) @(negedge clk);
    chk("halt_quiet", {bus.ifetch, bus.regsetwb, bus.mem_rd, bus.mem_wr, bus.halted}, 5'b00001);
    chk("events_drained", ev_q.size() + fe_q.size() + memlen_q.size() + lat_q.size(), 0);
`ifdef MCPU_CTRL_PERFCNT_EN
    chk("retired_count", retired, 16'(retired_m));
`endif

    run_en = 1'b0; mon_en = 1'b0; reset_n = 1'b0;
    #1 chk("reset_from_halt", outs(), RESET_OUTS);
    load_mode = 1'b1;
    @(negedge clk);
    reset_n = 1'b1; run_en = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 30 && !saw; i++) begin @(posedge clk); #2; saw = bus.mem_rd; end
    if (!saw) fail_now("load_mem_timeout");
    reset_n = 1'b0;
    #1 chk("reset_mid_mem", outs(), RESET_OUTS);
    run_en = 1'b0;
    #20;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_controlunit.md
Name: mcpu_controlunit

Overview:
- Multi-cycle sequencer for the MCPU.
- Fetches a 16-bit instruction and splits it into op1/op2/op3 operand fields.
- Drives the register file's regsetcmd and regsetwb strobe, the ALU operation select, and the data-memory read/write handshake.
- Sits directly upstream of the register file: its outputs are the register file's op1, op2, op3, regsetcmd and regsetwb inputs.

Parameters:
- WORD_SIZE, 16, instruction and data word width.
- OPERAND_SIZE, 4, width of each operand field.
- OPCODE_SIZE, 4, width of the opcode field.
- PC_WIDTH, 8, instruction address width.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- pc  output  PC_WIDTH  instruction address.
- ifetch  output  1  instruction request, one-cycle pulse.
- instr  input  WORD_SIZE  instruction word; sampled only when instr_valid=1.
- instr_valid  input  1  instruction-memory response valid.
- op1, op2, op3  output  OPERAND_SIZE  operand fields to the register file.
- aluop  output  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR.
- regsetcmd  output  2  register-file command: 0 NORMAL_EX, 1 MOV_INTERNAL, 2 LOAD_FROM_DATA, 3 DO_NOTHING.
- regsetwb  output  1  register-file write strobe.
- mem_rd  output  1  data-memory read request.
- mem_wr  output  1  data-memory write request.
- mem_ready  input  1  data-memory completion.
- halted  output  1  sticky halt indication.

Behaviour:
- Instruction format:
  - [15:12] opcode, [11:8] op1, [7:4] op2, [3:0] op3.
  - Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 MOV, 6 LOAD, 7 STORE, 8 JMP (target {op2,op3} truncated/zero-extended to PC_WIDTH), F HALT.
  - All other opcodes execute as NOP.
- Reset values (async, on reset_n=0):
  - state=FETCH, pc=0, IR=0.
  - op1/op2/op3=0, aluop=0, regsetcmd=3.
  - regsetwb, ifetch, mem_rd, mem_wr, halted all 0.
  - A reset mid-MEM drops mem_rd/mem_wr immediately; the transaction is abandoned.
- FSM, all outputs registered:
  - FETCH: ifetch=1 for exactly one cycle, pc stable; -> WAIT_I.
  - WAIT_I: hold until instr_valid=1, then latch IR; -> DECODE. Any number of wait cycles is allowed.
  - DECODE: load op1/op2/op3 from IR; set aluop and regsetcmd:
    - ALU ops -> 0; MOV -> 1; LOAD -> 2; NOP/STORE/JMP/HALT -> 3.
  - EXEC:
    - LOAD/STORE -> MEM.
    - ALU/MOV -> WB.
    - JMP: pc<=target; -> FETCH.
    - NOP/illegal: pc<=pc+1; -> FETCH.
    - HALT: halted<=1; -> HALT.
  - MEM: mem_rd (LOAD) or mem_wr (STORE) held high until the cycle mem_ready=1. Strobe deasserts the next cycle. LOAD -> WB; STORE: pc<=pc+1; -> FETCH.
  - WB: regsetwb=1 for exactly one cycle; pc<=pc+1; -> FETCH.
  - HALT: terminal; only reset exits. All strobes 0.
- Register-file timing rule: the register file writes shortly after the regsetwb rising edge. Therefore:
  - op1/op2/op3 and regsetcmd stay constant from DECODE through the cycle after WB, until the next DECODE.
  - regsetwb is never high when regsetcmd=3.
- pc increments modulo 2^PC_WIDTH (0xFF+1 -> 0x00).
- Minimum latency per instruction, with zero wait states:
  - ALU/MOV: 5 cycles.
  - LOAD: 6 cycles.
  - STORE: 5 cycles.
  - NOP/JMP: 4 cycles.
- mem_ready outside MEM and instr_valid outside WAIT_I are ignored.
- mem_ready already high on MEM entry completes MEM in one cycle.

Optional Feature:
- Macro: MCPU_CTRL_PERFCNT_EN.
- Defined:
  - Adds output retired [15:0], reset 0.
  - Increments by 1 on every transition out of WB, out of MEM for STORE, and out of EXEC for NOP/JMP/illegal.
  - HALT does not count.
  - Wraps 0xFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mcpu_pkg holds:
  - opcode constants.
  - regsetcmd encodings: NORMAL_EX, MOV_INTERNAL, LOAD_FROM_DATA, DO_NOTHING.
  - aluop encodings.
  - FSM state encoding: FETCH, WAIT_I, DECODE, EXEC, MEM, WB, HALT.
- One sub-module, mcpu_decoder: purely combinational. Maps opcode to {aluop, regsetcmd, is_mem, is_load, writes_reg, is_jmp, is_halt}.

Test Plan:
- Reset, then instr=0x1123 (ADD) with instr_valid one cycle after ifetch:
  - op1=1, op2=2, op3=3, aluop=0, regsetcmd=0.
  - regsetwb high exactly one cycle, 5 cycles after the FETCH pulse started; pc 0->1.
- MOV 0x5310: regsetcmd=1, one regsetwb pulse, op1=3 and op2=1 held through the cycle after WB.
- LOAD 0x6240 with mem_ready delayed 3 cycles:
  - mem_rd high 4 cycles, then regsetcmd=2 and one regsetwb pulse.
- STORE 0x7120: mem_wr until mem_ready; regsetwb never asserts; pc+1.
- JMP 0x80FE at pc=0x10: next ifetch has pc=0xFE. Then two NOPs: pc goes 0xFF, then wraps to 0x00.
- HALT 0xF000: halted=1 and no further ifetch. reset_n pulsed low mid-stream (also once during MEM) -> all outputs at reset values immediately, mem_rd=0.
